// File: rtl/repairclk_module_initiator.sv
// repairclk_module_initiator: initiator side of MBINIT.REPAIRCLK sideband handshake.
// Ports: CLK/rst_n clock and async active-low reset; i_MBINIT_CAL_end step enable;
// i_RX_SbMessage/i_msg_valid received sideband message; i_Clock_track_result partner result;
// i_Busy_SideBand/i_falling_edge_busy TX status; i_pattern_done pattern finished;
// o_TX_SbMessage/o_ValidOutData_Module message to send; o_pattern_en pattern enable;
// o_result_logged captured result; o_REPAIRCLK_Module_end step done; o_train_error failure.
module repairclk_module_initiator #(
  parameter int         TIMEOUT_CYCLES = 8000,
  parameter int         CNT_W          = 13,
  parameter logic [2:0] PASS_RESULT    = 3'b111
) (
  input  logic       CLK,
  input  logic       rst_n,
  input  logic       i_MBINIT_CAL_end,
  input  logic [3:0] i_RX_SbMessage,
  input  logic       i_msg_valid,
  input  logic [2:0] i_Clock_track_result,
  input  logic       i_Busy_SideBand,
  input  logic       i_falling_edge_busy,
  input  logic       i_pattern_done,
  output logic [3:0] o_TX_SbMessage,
  output logic       o_ValidOutData_Module,
  output logic       o_pattern_en,
  output logic [2:0] o_result_logged,
  output logic       o_REPAIRCLK_Module_end,
  output logic       o_train_error
);
  typedef enum logic [3:0] {
    IDLE, BUSY_INIT, SEND_INIT, WAIT_INIT, PATTERN, BUSY_RESULT, SEND_RESULT,
    WAIT_RESULT, BUSY_DONE, SEND_DONE, WAIT_DONE, DONE, ERROR
  } state_t;
  localparam logic [3:0] INIT_REQ    = 4'd1;
  localparam logic [3:0] INIT_RESP   = 4'd2;
  localparam logic [3:0] RESULT_REQ  = 4'd3;
  localparam logic [3:0] RESULT_RESP = 4'd4;
  localparam logic [3:0] DONE_REQ    = 4'd5;
  localparam logic [3:0] DONE_RESP   = 4'd6;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);
  state_t           r_cs, w_ns;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_tx;
  logic             r_valid, r_pattern_en, r_end, r_error;
  logic [2:0]       r_result;
  logic             w_timeout, w_init_resp, w_result_resp, w_done_resp;
  assign w_timeout     = r_cnt == CNT_MAX;
  assign w_init_resp   = i_msg_valid && i_RX_SbMessage == INIT_RESP;
  assign w_result_resp = i_msg_valid && i_RX_SbMessage == RESULT_RESP;
  assign w_done_resp   = i_msg_valid && i_RX_SbMessage == DONE_RESP;
  // An expected message arriving on the timeout cycle takes priority over the timeout.
  always_comb begin
    w_ns = r_cs;
    case (r_cs)
      IDLE:        w_ns = i_MBINIT_CAL_end ? BUSY_INIT : IDLE;
      BUSY_INIT:   w_ns = i_Busy_SideBand ? BUSY_INIT : SEND_INIT;
      SEND_INIT:   w_ns = i_falling_edge_busy ? WAIT_INIT : SEND_INIT;
      WAIT_INIT:   w_ns = w_init_resp ? PATTERN : w_timeout ? ERROR : WAIT_INIT;
      PATTERN:     w_ns = i_pattern_done ? BUSY_RESULT : w_timeout ? ERROR : PATTERN;
      BUSY_RESULT: w_ns = i_Busy_SideBand ? BUSY_RESULT : SEND_RESULT;
      SEND_RESULT: w_ns = i_falling_edge_busy ? WAIT_RESULT : SEND_RESULT;
      WAIT_RESULT: w_ns = w_result_resp ? (i_Clock_track_result == PASS_RESULT ? BUSY_DONE : ERROR)
                                        : w_timeout ? ERROR : WAIT_RESULT;
      BUSY_DONE:   w_ns = i_Busy_SideBand ? BUSY_DONE : SEND_DONE;
      SEND_DONE:   w_ns = i_falling_edge_busy ? WAIT_DONE : SEND_DONE;
      WAIT_DONE:   w_ns = w_done_resp ? DONE : w_timeout ? ERROR : WAIT_DONE;
      DONE:        w_ns = DONE;
      ERROR:       w_ns = ERROR;
      default:     w_ns = IDLE;
    endcase
    if (!i_MBINIT_CAL_end) w_ns = IDLE;
  end
  // Counter restarts on every state change so each wait gets a fresh budget; it saturates.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_cs         <= IDLE;
      r_cnt        <= '0;
      r_tx         <= '0;
      r_valid      <= 1'b0;
      r_pattern_en <= 1'b0;
      r_end        <= 1'b0;
      r_error      <= 1'b0;
      r_result     <= '0;
    end else begin
      r_cs         <= w_ns;
      r_cnt        <= (w_ns != r_cs) ? '0 : w_timeout ? r_cnt : r_cnt + CNT_W'(1);
      r_tx         <= w_ns == SEND_INIT ? INIT_REQ : w_ns == SEND_RESULT ? RESULT_REQ :
                      w_ns == SEND_DONE ? DONE_REQ : 4'd0;
      r_valid      <= w_ns == SEND_INIT || w_ns == SEND_RESULT || w_ns == SEND_DONE;
      r_pattern_en <= w_ns == PATTERN;
      r_end        <= w_ns == DONE;
      r_error      <= w_ns == ERROR;
      r_result     <= w_ns == IDLE ? 3'd0 :
                      (r_cs == WAIT_RESULT && w_result_resp) ? i_Clock_track_result : r_result;
    end
  end
  assign o_TX_SbMessage         = r_tx;
  assign o_ValidOutData_Module  = r_valid;
  assign o_pattern_en           = r_pattern_en;
  assign o_result_logged        = r_result;
  assign o_REPAIRCLK_Module_end = r_end;
  assign o_train_error          = r_error;
endmodule

// File: tb/tb_repairclk_module_initiator.sv
// tb_repairclk_module_initiator: self-checking bench for repairclk_module_initiator.
module tb_repairclk_module_initiator;
  localparam int T = 16;
  logic       CLK = 1'b0, rst_n = 1'b0, en = 1'b0;
  logic [3:0] rx = 4'd0;
  logic       mv = 1'b0, busy = 1'b0, fe = 1'b0, pdone = 1'b0;
  logic [2:0] res_in = 3'd0;
  logic [3:0] tx;
  logic       valid, pat_en, done_o, err;
  logic [2:0] res_log;
  int errors = 0, checks = 0;

  repairclk_module_initiator #(.TIMEOUT_CYCLES(T), .CNT_W(13), .PASS_RESULT(3'b111)) dut (
    .CLK(CLK), .rst_n(rst_n), .i_MBINIT_CAL_end(en), .i_RX_SbMessage(rx), .i_msg_valid(mv),
    .i_Clock_track_result(res_in), .i_Busy_SideBand(busy), .i_falling_edge_busy(fe),
    .i_pattern_done(pdone), .o_TX_SbMessage(tx), .o_ValidOutData_Module(valid),
    .o_pattern_en(pat_en), .o_result_logged(res_log), .o_REPAIRCLK_Module_end(done_o),
    .o_train_error(err));

  always #5 CLK = ~CLK;

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic send_rx(input logic [3:0] m, input logic v);
    rx = m; mv = v;
    step();
    rx = 4'd0; mv = 1'b0;
  endtask

  task automatic pulse_fe();
    fe = 1'b1;
    step();
    fe = 1'b0;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (valid) ok = 1'b1;
      else step();
    end
  endtask

  function automatic logic [13:0] outs();
    return {tx, valid, pat_en, res_log, done_o, err, 3'b000};
  endfunction

  task automatic test_reset();
    step(3);
    checks++;
    if (outs() !== 14'd0) begin errors++; $display("FAIL reset_outputs got=%h exp=0", outs()); end
    rst_n = 1'b1;
    step(2);
    checks++;
    if (outs() !== 14'd0) begin errors++; $display("FAIL idle_no_enable got=%h exp=0", outs()); end
  endtask

  // Randomised full handshakes; the model says a result equal to 111 completes, anything else errors.
  task automatic test_sequences();
    bit ok;
    for (int it = 0; it < 10; it++) begin
      logic [2:0] r;
      bit hold, pass;
      r    = it == 0 ? 3'b111 : it == 1 ? 3'b101 : ($urandom_range(0, 1) ? 3'b111 : 3'($urandom));
      hold = it == 2 || it == 3 || $urandom_range(0, 3) == 0;
      pass = r == 3'b111;
      busy = hold;
      en = 1'b1;
      if (hold) begin
        for (int i = 0; i < 5; i++) begin
          step();
          checks++;
          if (valid !== 1'b0) begin errors++; $display("FAIL busy_hold_init it=%0d got=%b exp=0", it, valid); end
        end
        busy = 1'b0;
      end
      wait_valid(ok);
      checks++;
      if (!ok || tx !== 4'd1) begin errors++; $display("FAIL init_req it=%0d got=%h exp=1", it, tx); end
      for (int i = 0, d = $urandom_range(0, 3); i < d; i++) begin
        step();
        checks++;
        if (valid !== 1'b1 || tx !== 4'd1) begin errors++; $display("FAIL init_hold it=%0d got=%b/%h exp=1/1", it, valid, tx); end
      end
      pulse_fe();
      checks++;
      if (valid !== 1'b0) begin errors++; $display("FAIL init_release it=%0d got=%b exp=0", it, valid); end
      step($urandom_range(0, 8));
      send_rx(4'd2, 1'b1);
      checks++;
      if (pat_en !== 1'b1) begin errors++; $display("FAIL pattern_en it=%0d got=%b exp=1", it, pat_en); end
      step($urandom_range(0, 8));
      pdone = 1'b1; busy = hold;
      step();
      pdone = 1'b0;
      checks++;
      if (pat_en !== 1'b0) begin errors++; $display("FAIL pattern_off it=%0d got=%b exp=0", it, pat_en); end
      if (hold) begin
        for (int i = 0; i < 5; i++) begin
          step();
          checks++;
          if (valid !== 1'b0) begin errors++; $display("FAIL busy_hold_result it=%0d got=%b exp=0", it, valid); end
        end
        busy = 1'b0;
      end
      wait_valid(ok);
      checks++;
      if (!ok || tx !== 4'd3) begin errors++; $display("FAIL result_req it=%0d got=%h exp=3", it, tx); end
      pulse_fe();
      step($urandom_range(0, 8));
      res_in = r; busy = hold;
      send_rx(4'd4, 1'b1);
      res_in = 3'($urandom);
      checks++;
      if (res_log !== r || err !== !pass) begin
        errors++; $display("FAIL result_capture it=%0d got=%b/%b exp=%b/%b", it, res_log, err, r, !pass);
      end
      if (pass) begin
        if (hold) begin
          for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (valid !== 1'b0) begin errors++; $display("FAIL busy_hold_done it=%0d got=%b exp=0", it, valid); end
          end
          busy = 1'b0;
        end
        wait_valid(ok);
        checks++;
        if (!ok || tx !== 4'd5) begin errors++; $display("FAIL done_req it=%0d got=%h exp=5", it, tx); end
        pulse_fe();
        step($urandom_range(0, 8));
        send_rx(4'd6, 1'b1);
        step(2);
        checks++;
        if (done_o !== 1'b1 || err !== 1'b0 || res_log !== r) begin
          errors++; $display("FAIL done_state it=%0d got=%b/%b/%b exp=1/0/%b", it, done_o, err, res_log, r);
        end
      end else begin
        busy = 1'b0;
        for (int i = 0; i < 6; i++) begin
          step();
          checks++;
          if (valid !== 1'b0 || err !== 1'b1 || res_log !== r) begin
            errors++; $display("FAIL error_hold it=%0d got=%b/%b/%b exp=0/1/%b", it, valid, err, res_log, r);
          end
        end
      end
      en = 1'b0;
      step();
      checks++;
      if (outs() !== 14'd0) begin errors++; $display("FAIL disable_clear it=%0d got=%h exp=0", it, outs()); end
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int n;
    en = 1'b1;
    wait_valid(ok);
    pulse_fe();
    n = 0;
    while (!err && n < 40) begin
      step();
      n++;
    end
    checks++;
    if (n != T) begin errors++; $display("FAIL timeout_latency got=%0d exp=%0d", n, T); end
    en = 1'b0;
    step();
    checks++;
    if (outs() !== 14'd0) begin errors++; $display("FAIL timeout_clear got=%h exp=0", outs()); end
  endtask

  task automatic test_timeout_race();
    bit ok;
    en = 1'b1;
    wait_valid(ok);
    pulse_fe();
    step(T - 1);
    send_rx(4'd2, 1'b1);
    checks++;
    if (pat_en !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL msg_beats_timeout got=%b/%b exp=1/0", pat_en, err); end
    en = 1'b0;
    step();
  endtask

  task automatic test_noise();
    bit ok;
    en = 1'b1;
    wait_valid(ok);
    pulse_fe();
    send_rx(4'd6, 1'b1);
    send_rx(4'd2, 1'b0);
    send_rx(4'd4, 1'b1);
    checks++;
    if (pat_en !== 1'b0 || err !== 1'b0 || valid !== 1'b0) begin
      errors++; $display("FAIL noise_wait_init got=%b/%b/%b exp=0/0/0", pat_en, err, valid);
    end
    send_rx(4'd2, 1'b1);
    send_rx(4'd2, 1'b1);
    checks++;
    if (pat_en !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL noise_pattern got=%b/%b exp=1/0", pat_en, err); end
    en = 1'b0;
    step();
  endtask

  task automatic test_abort();
    bit ok;
    en = 1'b1;
    wait_valid(ok);
    pulse_fe();
    send_rx(4'd2, 1'b1);
    step(3);
    en = 1'b0;
    step();
    checks++;
    if (outs() !== 14'd0) begin errors++; $display("FAIL abort_clear got=%h exp=0", outs()); end
    en = 1'b1;
    wait_valid(ok);
    checks++;
    if (!ok || tx !== 4'd1) begin errors++; $display("FAIL abort_restart got=%h exp=1", tx); end
    en = 1'b0;
    step();
  endtask

  task automatic test_async_reset();
    bit ok;
    en = 1'b1;
    wait_valid(ok);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (outs() !== 14'd0) begin errors++; $display("FAIL async_reset got=%h exp=0", outs()); end
    en = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_sequences();
    test_timeout();
    test_timeout_race();
    test_noise();
    test_abort();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
